// File: rtl/ex_result_stage.sv
// ex_result_stage
// Execute-stage result collector. Sequences the shifter enable/busy handshake,
// captures the finished ALU or shift result into a one-entry output slot and
// hands that slot downstream over valid/ready. Works with both bit-serial
// shifters (busy held for n cycles) and barrel shifters (busy never high).
module ex_result_stage (
    input  logic        i_clk_n,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_is_shift,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_shift_result,
    input  logic        i_shift_busy,
    input  logic [4:0]  i_rd,
    input  logic        i_wb_en,
    input  logic        i_flush,
    input  logic        i_ready,
    output logic        o_shift_en,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd,
    output logic        o_wb_en
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        slot_free_s;
    logic        cap_alu_s;
    logic        cap_shift_s;
    logic        stall_s;
    logic        shift_en_s;

    logic        valid_r;
    logic [31:0] result_r;
    logic [4:0]  rd_r;
    logic        wb_en_r;

    // Decode next state, stall, shifter enable and capture strobes from the current state
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        shift_en_s  = 1'b0;
        cap_alu_s   = 1'b0;
        cap_shift_s = 1'b0;
        slot_free_s = !valid_r || i_ready;
        case (state_r)
            ST_IDLE: begin
                if (i_flush) begin
                    // killed instruction: nothing captured, nothing started
                    state_nxt_s = ST_IDLE;
                end else if (i_valid && i_is_shift) begin
                    state_nxt_s = ST_ISSUE;
                    stall_s     = 1'b1;
                end else if (i_valid && slot_free_s) begin
                    cap_alu_s   = 1'b1;
                end else if (i_valid) begin
                    stall_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // one enable cycle so the shifter has loaded before busy is looked at
                shift_en_s = 1'b1;
                if (i_flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                    stall_s     = 1'b1;
                end
            end
            ST_WAIT: begin
                // keep enable through the last step (SRA sign fill), drop it so
                // a finished shifter does not reload
                shift_en_s = i_shift_busy;
                if (i_flush) begin
                    state_nxt_s = ST_DRAIN;
                end else if (!i_shift_busy && slot_free_s) begin
                    cap_shift_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall_s     = 1'b1;
                end
            end
            ST_DRAIN: begin
                // a flushed shift must finish before the shifter can preload again
                stall_s = !i_flush;
                if (!i_shift_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Stall is combinational; the EX valid is ignored while reset is asserted
    assign o_stall    = stall_s & i_rst_n;
    assign o_shift_en = shift_en_s;

    // Sequencer state register
    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // One-entry output slot: load on capture, release on downstream accept, else hold
    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r  <= 1'b0;
            result_r <= 32'd0;
            rd_r     <= 5'd0;
            wb_en_r  <= 1'b0;
        end else if (cap_alu_s) begin
            valid_r  <= 1'b1;
            result_r <= i_alu_result;
            rd_r     <= i_rd;
            wb_en_r  <= i_wb_en;
        end else if (cap_shift_s) begin
            valid_r  <= 1'b1;
            result_r <= i_shift_result;
            rd_r     <= i_rd;
            wb_en_r  <= i_wb_en;
        end else if (i_ready) begin
            valid_r  <= 1'b0;
        end else begin
            valid_r  <= valid_r;
        end
    end

    assign o_valid  = valid_r;
    assign o_result = result_r;
    assign o_rd     = rd_r;
    assign o_wb_en  = wb_en_r;

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage
// Table-driven directed vectors, hand-written corner sequences and randomized
// traffic checked by an in-order scoreboard of expected write-back records.
// The shifter is a behavioural bench model (bit-serial or barrel).
module tb_ex_result_stage;

    logic        i_clk_n = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_is_shift = 1'b0;
    logic [31:0] i_alu_result = 32'd0;
    logic [31:0] i_shift_result;
    logic        i_shift_busy;
    logic [4:0]  i_rd = 5'd0;
    logic        i_wb_en = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_shift_en;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd;
    logic        o_wb_en;

    int vectors = 0;
    int miscompares = 0;

    ex_result_stage dut (
        .i_clk_n        (i_clk_n),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_is_shift     (i_is_shift),
        .i_alu_result   (i_alu_result),
        .i_shift_result (i_shift_result),
        .i_shift_busy   (i_shift_busy),
        .i_rd           (i_rd),
        .i_wb_en        (i_wb_en),
        .i_flush        (i_flush),
        .i_ready        (i_ready),
        .o_shift_en     (o_shift_en),
        .o_stall        (o_stall),
        .o_valid        (o_valid),
        .o_result       (o_result),
        .o_rd           (o_rd),
        .o_wb_en        (o_wb_en)
    );

    always #5 i_clk_n = ~i_clk_n;

    // kind: 0 = ALU, 1 = SLL, 2 = SRL, 3 = SRA
    int          cur_kind = 0;
    logic [31:0] cur_a = 32'd0;
    int          cur_amt = 0;
    logic [4:0]  cur_rd = 5'd0;
    logic        cur_wb = 1'b0;
    bit          barrel = 1'b0;

    function automatic logic [31:0] ref_result(input int kind, input logic [31:0] a, input int amt);
        case (kind)
            1: return a << amt;
            2: return a >> amt;
            3: return $unsigned($signed(a) >>> amt);
            default: return a;
        endcase
    endfunction

    // Behavioural shifter: enable while idle loads, busy for 'amount' cycles (never on barrel)
    logic        sh_busy;
    logic [31:0] sh_res;
    int          sh_cnt;
    always @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_busy <= 1'b0;
            sh_res  <= 32'd0;
            sh_cnt  <= 0;
        end else if (sh_busy) begin
            sh_cnt  <= sh_cnt - 1;
            sh_busy <= (sh_cnt > 1);
        end else if (o_shift_en) begin
            sh_res  <= ref_result(cur_kind, cur_a, cur_amt);
            sh_cnt  <= cur_amt;
            sh_busy <= !barrel && (cur_amt != 0);
        end
    end
    assign i_shift_busy   = sh_busy;
    assign i_shift_result = sh_busy ? 32'hDEAD_BEEF : sh_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of results owed to the write-back stage, in order
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb;
    } exp_t;
    exp_t exp_q[$];

    task automatic monitor_step();
        exp_t e;
        if (!i_rst_n) begin
            exp_q.delete();
        end else begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, o_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("sb_result", o_result, e.res);
                    chk("sb_rd", {27'd0, o_rd}, {27'd0, e.rd});
                    chk("sb_wb_en", {31'd0, o_wb_en}, {31'd0, e.wb});
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            // the EX instruction leaves this cycle and was not killed -> a result is owed
            if (i_valid && !o_stall && !i_flush) begin
                e.res = ref_result(cur_kind, cur_a, cur_amt);
                e.rd  = cur_rd;
                e.wb  = cur_wb;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge i_clk_n);
            monitor_step();
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk_n);
        #1;
    endtask

    task automatic present(input int kind, input logic [31:0] a, input int amt,
                           input logic [4:0] rd, input logic wb);
        cur_kind     = kind;
        cur_a        = a;
        cur_amt      = amt;
        cur_rd       = rd;
        cur_wb       = wb;
        i_valid      = 1'b1;
        i_is_shift   = (kind != 0);
        i_alu_result = (kind == 0) ? a : $urandom;
        i_rd         = rd;
        i_wb_en      = wb;
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_is_shift   = 1'b0;
        i_alu_result = $urandom;
    endtask

    // Present one instruction until EX releases it; count stall and enable cycles
    task automatic run_op(input int kind, input logic [31:0] a, input int amt,
                          input logic [4:0] rd, input logic wb,
                          output int stalls, output int ens, output bit ok);
        stalls = 0;
        ens    = 0;
        ok     = 1'b0;
        present(kind, a, amt, rd, wb);
        for (int c = 0; c < 200; c++) begin
            @(negedge i_clk_n);
            if (o_shift_en) ens++;
            if (o_stall) begin
                stalls++;
                tick();
            end else begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    {31'd0, o_valid},    32'd0);
        chk({tag, "_result"},   o_result,            32'd0);
        chk({tag, "_rd"},       {27'd0, o_rd},       32'd0);
        chk({tag, "_wb_en"},    {31'd0, o_wb_en},    32'd0);
        chk({tag, "_shift_en"}, {31'd0, o_shift_en}, 32'd0);
        chk({tag, "_stall"},    {31'd0, o_stall},    32'd0);
    endtask

    typedef struct {
        int          kind;
        logic [31:0] a;
        int          amt;
        logic [4:0]  rd;
        logic        wb;
        bit          brl;
        logic [31:0] exp_res;
        int          exp_stall;
        int          exp_en;
    } vec_t;

    vec_t tab[8];

    initial begin
        int  stalls;
        int  ens;
        bit  ok;
        bit  done;
        int  kind;
        int  amt;

        tab[0] = '{0, 32'h1234_5678, 0,  5'd5,  1'b1, 1'b0, 32'h1234_5678, 0,  0};
        tab[1] = '{1, 32'h0000_0001, 4,  5'd1,  1'b1, 1'b0, 32'h0000_0010, 6,  5};
        tab[2] = '{1, 32'h0000_00C3, 0,  5'd2,  1'b1, 1'b0, 32'h0000_00C3, 2,  1};
        tab[3] = '{3, 32'h8000_0000, 31, 5'd3,  1'b1, 1'b0, 32'hFFFF_FFFF, 33, 32};
        tab[4] = '{2, 32'h8000_0000, 31, 5'd4,  1'b0, 1'b0, 32'h0000_0001, 33, 32};
        tab[5] = '{3, 32'h8000_0000, 31, 5'd6,  1'b1, 1'b1, 32'hFFFF_FFFF, 2,  1};
        tab[6] = '{2, 32'h8000_0000, 31, 5'd7,  1'b1, 1'b1, 32'h0000_0001, 2,  1};
        tab[7] = '{0, 32'hDEAD_C0DE, 0,  5'd31, 1'b0, 1'b0, 32'hDEAD_C0DE, 0,  0};

        // power-on reset
        #1 i_rst_n = 1'b0;
        #11;
        chk_reset_outputs("por");
        tick();
        i_rst_n = 1'b1;
        tick();

        // directed table
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            barrel = tab[k].brl;
            run_op(tab[k].kind, tab[k].a, tab[k].amt, tab[k].rd, tab[k].wb, stalls, ens, ok);
            chk($sformatf("v%0d_done", k), {31'd0, ok}, 32'd1);
            chk($sformatf("v%0d_stall_cycles", k), stalls, tab[k].exp_stall);
            chk($sformatf("v%0d_shift_en_cycles", k), ens, tab[k].exp_en);
            @(negedge i_clk_n);
            chk($sformatf("v%0d_valid", k), {31'd0, o_valid}, 32'd1);
            chk($sformatf("v%0d_result", k), o_result, tab[k].exp_res);
            chk($sformatf("v%0d_rd", k), {27'd0, o_rd}, {27'd0, tab[k].rd});
            chk($sformatf("v%0d_wb_en", k), {31'd0, o_wb_en}, {31'd0, tab[k].wb});
            tick();
        end
        barrel = 1'b0;

        // back-to-back ALU stream: no stall, one result per cycle
        for (int i = 0; i < 4; i++) begin
            present(0, 32'h0000_1000 + i, 0, 5'(i + 1), 1'b1);
            @(negedge i_clk_n);
            chk("stream_stall", {31'd0, o_stall}, 32'd0);
            if (i > 0) chk("stream_valid", {31'd0, o_valid}, 32'd1);
            tick();
        end
        idle_inputs();
        @(negedge i_clk_n);
        chk("stream_last_valid", {31'd0, o_valid}, 32'd1);
        chk("stream_last_result", o_result, 32'h0000_1003);
        tick();

        // backpressure: slot blocked, shift of 8 finishes but waits
        i_ready = 1'b0;
        run_op(0, 32'hCAFE_0001, 0, 5'd7, 1'b1, stalls, ens, ok);
        chk("bp_first_done", {31'd0, ok}, 32'd1);
        present(1, 32'h0000_0001, 8, 5'd9, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk_n);
            chk("bp_stall", {31'd0, o_stall}, 32'd1);
            if (c == 19) begin
                chk("bp_shift_en_low", {31'd0, o_shift_en}, 32'd0);
                chk("bp_payload", o_result, 32'hCAFE_0001);
            end
            tick();
        end
        i_ready = 1'b1;
        @(negedge i_clk_n);
        chk("bp_release_stall", {31'd0, o_stall}, 32'd0);
        tick();
        idle_inputs();
        @(negedge i_clk_n);
        chk("bp_shift_valid", {31'd0, o_valid}, 32'd1);
        chk("bp_shift_result", o_result, 32'h0000_0100);
        tick();

        // flush during WAIT of a 20-step shift, then SLL 3 behind the drain
        present(2, 32'hF0F0_F0F0, 20, 5'd3, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk_n);
            chk("fl_pre_stall", {31'd0, o_stall}, 32'd1);
            tick();
        end
        i_flush = 1'b1;
        @(negedge i_clk_n);
        chk("fl_stall", {31'd0, o_stall}, 32'd0);
        chk("fl_slot", {31'd0, o_valid}, 32'd0);
        tick();
        i_flush = 1'b0;
        run_op(1, 32'h0000_0005, 3, 5'd4, 1'b1, stalls, ens, ok);
        chk("fl_next_done", {31'd0, ok}, 32'd1);
        chk("fl_next_stall_cycles", stalls, 24);
        chk("fl_next_shift_en_cycles", ens, 4);
        @(negedge i_clk_n);
        chk("fl_next_result", o_result, 32'h0000_0028);
        tick();

        // asynchronous reset in the middle of a cycle
        i_ready = 1'b0;
        run_op(0, 32'hA5A5_5A5A, 0, 5'd12, 1'b1, stalls, ens, ok);
        present(1, 32'h0000_0001, 5, 5'd3, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        idle_inputs();
        i_ready = 1'b1;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();

        // randomized traffic: bit-serial shifter, then barrel shifter
        for (int ph = 0; ph < 2; ph++) begin
            barrel = (ph == 1);
            for (int n = 0; n < 250; n++) begin
                kind = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                amt  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 10));
                present(kind, $urandom, amt, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                done = 1'b0;
                for (int c = 0; c < 200 && !done; c++) begin
                    i_ready = ($urandom_range(0, 9) < 7);
                    i_flush = ($urandom_range(0, 24) == 0);
                    @(negedge i_clk_n);
                    if (!o_stall) done = 1'b1;
                    else tick();
                end
                chk("rand_progress", {31'd0, done}, 32'd1);
                tick();
                i_flush = 1'b0;
                idle_inputs();
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        // drain and confirm every owed result was delivered
        i_ready = 1'b1;
        i_flush = 1'b0;
        for (int c = 0; c < 40; c++) tick();
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-stage result collector sitting directly downstream of the shifter and the ALU. It sequences the shifter's enable/busy handshake and captures the finished ALU or shift result into a one-entry output register. That register is handed to the memory/writeback stage over a valid/ready handshake. The block stalls the upstream pipeline while a shift is in flight or the output slot is blocked, and works unchanged with both the bit-serial and the barrel shifter builds.

## Interface
No parameters.
- i_clk_n  in  1  inverted clock; all state updates on its rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  instruction present in EX; operands and payload are held stable while o_stall=1
- i_is_shift  in  1  EX instruction is a shift (funct3 001/101)
- i_alu_result  in  32  ALU result, combinational, valid when i_valid
- i_shift_result  in  32  shifter result
- i_shift_busy  in  1  shifter busy
- i_rd  in  5  destination register
- i_wb_en  in  1  register write enable of the EX instruction
- i_flush  in  1  kill the EX instruction (branch taken / trap)
- i_ready  in  1  downstream accepts the output slot this cycle
- o_shift_en  out  1  shifter enable
- o_stall  out  1  hold the EX instruction; combinational
- o_valid  out  1  output slot holds a result
- o_result  out  32  captured result
- o_rd  out  5  captured destination register
- o_wb_en  out  1  captured write enable

## Operation
- Define slot_free = !o_valid || i_ready.
- Define capture = the output register loads {result, i_rd, i_wb_en} and sets o_valid=1.
- If no capture occurs and i_ready=1, o_valid clears.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - i_valid && !i_is_shift && slot_free: capture i_alu_result; o_stall=0.
  - i_valid && !i_is_shift && !slot_free: o_stall=1.
  - i_valid && i_is_shift: go to ISSUE; o_stall=1.
- ISSUE: o_shift_en=1, o_stall=1, no capture. Always go to WAIT. This guarantees the shifter has loaded before busy is sampled.
- WAIT:
  - o_shift_en = i_shift_busy. Enable is held through the last shift step so SRA sign-fill stays valid, and drops once busy is low so the shifter does not reload.
  - !i_shift_busy && slot_free: capture i_shift_result; o_stall=0; go to IDLE.
  - Otherwise: o_stall=1; stay in WAIT.
- DRAIN: o_shift_en=0, o_stall=1. Go to IDLE when !i_shift_busy.
- i_flush (synchronous, highest priority over capture of the EX instruction):
  - From IDLE: no capture; stay in IDLE.
  - From ISSUE or WAIT: go to DRAIN. The in-flight shift must complete before the shifter can preload again.
  - In all cases o_stall=0 that cycle, and the output slot and its contents are unaffected.
- i_valid=0 in IDLE: no action, o_stall=0.

## Timing
- Reset (async, i_rst_n=0): state=IDLE, o_valid=0, o_result=0, o_rd=0, o_wb_en=0, o_shift_en=0, o_stall=0 (combinational from IDLE with i_valid ignored during reset).
- Deassertion of reset takes effect at the next rising edge of i_clk_n.
- ALU op latency: presented in cycle 0 with slot free → o_valid=1 in cycle 1.
- Bit shifter, amount n: ISSUE in cycle 0, WAIT in cycles 1..n+1, capture at the end of cycle n+1, o_valid in cycle n+2. For n=0 the capture occurs in cycle 1.
- Barrel shifter: busy is never high, so capture occurs at the end of cycle 1 and o_valid=1 in cycle 2.
- Payload o_result/o_rd/o_wb_en stays stable while o_valid && !i_ready.
- Back-to-back: capture and downstream accept in the same cycle are legal, giving one ALU op per cycle.
- Reset mid-shift returns to IDLE immediately. The shifter shares the reset and clears too.

## Test plan
- Reset: drive i_rst_n=0 mid-cycle → all outputs 0 at once. Release it, then ALU op 0x12345678 rd=5 with i_ready=1 → o_valid=1, o_result=0x12345678, o_rd=5 the next cycle.
- SLL of 0x00000001 by 4 on the bit shifter → o_stall high for 6 cycles, o_shift_en high in ISSUE and 4 WAIT cycles, o_result=0x00000010 in cycle 6. Repeat with amount 0 → o_result=in_a in cycle 2.
- SRA of 0x80000000 by 31 → o_result=0xFFFFFFFF. SRL of the same value by 31 → 0x00000001. On the barrel build both take 2 cycles.
- Backpressure: hold i_ready=0 with o_valid=1, then issue a shift of 8 → the shift finishes but stays in WAIT, o_stall=1, and the payload is unchanged. Raise i_ready → capture occurs that same cycle.
- Flush during WAIT of a 20-bit shift → DRAIN holds o_stall=1 until busy drops. The next SLL of 3 is then correct and the output slot is untouched.
- Stream of 4 ALU ops with i_ready=1 → 4 consecutive o_valid cycles, no stall.
